// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: MEM/WB forwarding for A, B and predicate P,
// load-use stall detection and the ID/EX pipeline register.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   id_*            decoded instruction fields from ID
//   rf_bus_a/b/p    register file read data for Rs, Rt, Rp
//   mem_*, wb_*     in-flight results for forwarding
//   flush           kill the ID instruction (bubble into EX)
//   stall           comb load-use stall to fetch and IF/ID
//   ex_*            registered ID/EX outputs
//   stall_cnt       saturating count of stall cycles
module id_ex_operand_stage #(
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rp,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic              id_regw,
  input  logic              id_memrd,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       rf_bus_a,
  input  logic [31:0]       rf_bus_b,
  input  logic [31:0]       rf_bus_p,
  input  logic              mem_regw,
  input  logic [4:0]        mem_rd,
  input  logic [31:0]       mem_result,
  input  logic              wb_regw,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_result,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_b,
  output logic              ex_pred_ok,
  output logic [4:0]        ex_rd,
  output logic              ex_regw,
  output logic              ex_memrd,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] fwd_p;
  logic        pred_ok;
  logic        hazard;
  logic        bubble;

  // r0 reads as zero; r30 is the PC and only the
  // register file bus carries its value.
  function automatic logic [31:0] pick(
    input logic [4:0]  idx,
    input logic [31:0] bus,
    input logic        mw,
    input logic [4:0]  mr,
    input logic [31:0] mv,
    input logic        ww,
    input logic [4:0]  wr,
    input logic [31:0] wv
  );
    logic [31:0] v;
    if (idx == 5'd0)
      v = '0;
    else if (idx == 5'd30)
      v = bus;
    else if (mw && mr == idx)
      v = mv;
    else if (ww && wr == idx)
      v = wv;
    else
      v = bus;
    return v;
  endfunction

  always_comb begin
    fwd_a = pick(id_rs, rf_bus_a,
                 mem_regw, mem_rd, mem_result,
                 wb_regw, wb_rd, wb_result);
    fwd_b = pick(id_rt, rf_bus_b,
                 mem_regw, mem_rd, mem_result,
                 wb_regw, wb_rd, wb_result);
    fwd_p = pick(id_rp, rf_bus_p,
                 mem_regw, mem_rd, mem_result,
                 wb_regw, wb_rd, wb_result);
    pred_ok = (id_rp == 5'd0) || (fwd_p != '0);
  end

  always_comb begin
    hazard = ex_valid && ex_memrd
          && (ex_rd != 5'd0) && id_valid
          && ((ex_rd == id_rs)
           || (id_uses_rt && ex_rd == id_rt)
           || (id_rp != 5'd0 && ex_rd == id_rp));
    stall  = hazard && !flush;
    bubble = flush || stall || !id_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_pred_ok <= 1'b0;
      ex_rd      <= '0;
      ex_regw    <= 1'b0;
      ex_memrd   <= 1'b0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
    end else if (bubble) begin
      ex_valid   <= 1'b0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_pred_ok <= 1'b0;
      ex_rd      <= '0;
      ex_regw    <= 1'b0;
      ex_memrd   <= 1'b0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
    end else begin
      ex_valid   <= 1'b1;
      ex_a       <= fwd_a;
      ex_b       <= fwd_b;
      ex_pred_ok <= pred_ok;
      ex_rd      <= id_rd;
      ex_regw    <= id_regw && pred_ok;
      ex_memrd   <= id_memrd && pred_ok;
      ex_imm     <= id_imm;
      ex_ctrl    <= id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed steps then random
// traffic against a register-view model of the stage.
module tb_id_ex_operand_stage;

  localparam int CW = 12;
  localparam int NW = 2;

  logic          clk;
  logic          reset;
  logic          id_valid;
  logic [4:0]    id_rs, id_rt, id_rp, id_rd;
  logic          id_uses_rt, id_regw, id_memrd;
  logic [31:0]   id_imm;
  logic [CW-1:0] id_ctrl;
  logic [31:0]   rf_bus_a, rf_bus_b, rf_bus_p;
  logic          mem_regw;
  logic [4:0]    mem_rd;
  logic [31:0]   mem_result;
  logic          wb_regw;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_result;
  logic          flush;
  logic          stall;
  logic          ex_valid;
  logic [31:0]   ex_a, ex_b;
  logic          ex_pred_ok;
  logic [4:0]    ex_rd;
  logic          ex_regw, ex_memrd;
  logic [31:0]   ex_imm;
  logic [CW-1:0] ex_ctrl;
  logic [NW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_operand_stage #(.CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rp(id_rp), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_regw(id_regw),
    .id_memrd(id_memrd), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rf_bus_a(rf_bus_a), .rf_bus_b(rf_bus_b),
    .rf_bus_p(rf_bus_p),
    .mem_regw(mem_regw), .mem_rd(mem_rd),
    .mem_result(mem_result),
    .wb_regw(wb_regw), .wb_rd(wb_rd), .wb_result(wb_result),
    .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_pred_ok(ex_pred_ok), .ex_rd(ex_rd),
    .ex_regw(ex_regw), .ex_memrd(ex_memrd),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // model of what EX holds
  logic          m_valid, m_pok, m_regw, m_memrd;
  logic [31:0]   m_a, m_b, m_imm;
  logic [4:0]    m_rd;
  logic [CW-1:0] m_ctrl;
  int            m_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // value of register idx as the ID instruction should see it
  function automatic logic [31:0] view(input logic [4:0] idx,
                                       input logic [31:0] bus);
    if (idx == 0) return 32'd0;
    if (idx == 30) return bus;
    if (mem_regw && mem_rd == idx) return mem_result;
    if (wb_regw && wb_rd == idx) return wb_result;
    return bus;
  endfunction

  function automatic logic load_use();
    logic dep;
    dep = (m_rd == id_rs)
       || (id_uses_rt && m_rd == id_rt)
       || (id_rp != 0 && m_rd == id_rp);
    return m_valid && m_memrd && m_rd != 0 && id_valid && dep;
  endfunction

  task automatic step();
    logic es, pok, live;
    #1;
    es = load_use() && !flush;
    chk("stall", 32'(stall), 32'(es));
    pok = (id_rp == 0) || (view(id_rp, rf_bus_p) != 0);
    live = !reset && !flush && !es && id_valid;
    if (reset) m_cnt = 0;
    else if (es && m_cnt < (1 << NW) - 1) m_cnt++;
    m_valid = live;
    m_a     = live ? view(id_rs, rf_bus_a) : 32'd0;
    m_b     = live ? view(id_rt, rf_bus_b) : 32'd0;
    m_pok   = live && pok;
    m_rd    = live ? id_rd : 5'd0;
    m_regw  = live && id_regw && pok;
    m_memrd = live && id_memrd && pok;
    m_imm   = live ? id_imm : 32'd0;
    m_ctrl  = live ? id_ctrl : '0;
    @(posedge clk);
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("ex_a", ex_a, m_a);
    chk("ex_b", ex_b, m_b);
    chk("ex_pred_ok", 32'(ex_pred_ok), 32'(m_pok));
    chk("ex_rd", 32'(ex_rd), 32'(m_rd));
    chk("ex_regw", 32'(ex_regw), 32'(m_regw));
    chk("ex_memrd", 32'(ex_memrd), 32'(m_memrd));
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    chk("stall_post", 32'(stall),
        32'(load_use() && !flush));
  endtask

  function automatic logic [4:0] rnd_idx();
    int r;
    r = $urandom_range(0, 7);
    return (r == 7) ? 5'd30 : 5'(r);
  endfunction

  initial begin
    clk = 0; reset = 1; flush = 0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rp = 0; id_rd = 0;
    id_uses_rt = 0; id_regw = 0; id_memrd = 0;
    id_imm = 0; id_ctrl = 0;
    rf_bus_a = 0; rf_bus_b = 0; rf_bus_p = 0;
    mem_regw = 0; mem_rd = 0; mem_result = 0;
    wb_regw = 0; wb_rd = 0; wb_result = 0;
    m_valid = 0; m_pok = 0; m_regw = 0; m_memrd = 0;
    m_a = 0; m_b = 0; m_imm = 0; m_rd = 0; m_ctrl = 0;
    m_cnt = 0;
    @(posedge clk); #1;
    step();
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    reset = 0;

    // forwarding priority
    id_valid = 1; id_rs = 3; id_rd = 4; id_regw = 1;
    id_imm = 32'h11; id_ctrl = 12'h5a5;
    rf_bus_a = 100;
    mem_regw = 1; mem_rd = 3; mem_result = 7;
    wb_regw = 1; wb_rd = 3; wb_result = 9;
    step();
    chk("fwd_mem", ex_a, 32'd7);
    mem_regw = 0;
    step();
    chk("fwd_wb", ex_a, 32'd9);
    wb_regw = 0;
    step();
    chk("fwd_rf", ex_a, 32'd100);

    // r0 and r30
    id_rs = 0; mem_regw = 1; mem_rd = 0; mem_result = 55;
    step();
    chk("r0", ex_a, 32'd0);
    id_rt = 30; id_uses_rt = 1; mem_rd = 30; rf_bus_b = 40;
    step();
    chk("r30", ex_b, 32'd40);
    mem_regw = 0; id_rt = 0;

    // load-use stall, then MEM forward
    id_memrd = 1; id_rd = 5; id_rs = 1;
    step();
    id_memrd = 0; id_rd = 6; id_rs = 5;
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    step();
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    mem_regw = 1; mem_rd = 5; mem_result = 32'h1234;
    step();
    chk("lu_issue", ex_a, 32'h1234);
    mem_regw = 0;

    // Rt unused: no stall
    id_memrd = 1; id_rd = 5; id_rs = 1;
    step();
    id_memrd = 0; id_rd = 6; id_rt = 5; id_uses_rt = 0;
    #1;
    chk("rt_unused", 32'(stall), 32'd0);
    step();
    id_rt = 0;

    // predicates
    id_rp = 10; rf_bus_p = 0; id_regw = 1;
    step();
    chk("pred_f_ok", 32'(ex_pred_ok), 32'd0);
    chk("pred_f_regw", 32'(ex_regw), 32'd0);
    chk("pred_f_valid", 32'(ex_valid), 32'd1);
    id_rp = 20; rf_bus_p = 1;
    step();
    chk("pred_t_regw", 32'(ex_regw), 32'd1);
    id_rp = 10; rf_bus_p = 0;
    mem_regw = 1; mem_rd = 10; mem_result = 1;
    step();
    chk("pred_fwd", 32'(ex_pred_ok), 32'd1);
    mem_regw = 0; id_rp = 0;

    // flush beats stall
    id_memrd = 1; id_rd = 5; id_rs = 1;
    step();
    id_memrd = 0; id_rd = 6; id_rs = 5; flush = 1;
    #1;
    chk("fl_stall", 32'(stall), 32'd0);
    step();
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_cnt", 32'(stall_cnt), 32'd1);
    flush = 0;

    // saturation: lw r5,0(r5) repeated stalls every other cycle
    id_memrd = 1; id_rd = 5; id_rs = 5;
    for (int i = 0; i < 10; i++) step();
    chk("sat_cnt", 32'(stall_cnt), 32'd3);

    // reset in a stall cycle
    id_valid = 0;
    step();
    id_valid = 1;
    step();
    reset = 1;
    #1;
    chk("rs_pre_stall", 32'(stall), 32'd1);
    step();
    chk("rs_valid", 32'(ex_valid), 32'd0);
    chk("rs_a", ex_a, 32'd0);
    chk("rs_rd", 32'(ex_rd), 32'd0);
    chk("rs_cnt", 32'(stall_cnt), 32'd0);
    chk("rs_stall", 32'(stall), 32'd0);
    reset = 0;

    // random traffic
    for (int i = 0; i < 500; i++) begin
      reset      = ($urandom_range(0, 63) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      id_valid   = ($urandom_range(0, 5) != 0);
      id_rs      = rnd_idx();
      id_rt      = rnd_idx();
      id_rp      = ($urandom_range(0, 2) == 0) ? rnd_idx() : 5'd0;
      id_rd      = rnd_idx();
      id_uses_rt = 1'($urandom);
      id_regw    = 1'($urandom);
      id_memrd   = ($urandom_range(0, 2) == 0);
      id_imm     = $urandom;
      id_ctrl    = CW'($urandom);
      rf_bus_a   = $urandom;
      rf_bus_b   = $urandom;
      rf_bus_p   = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      mem_regw   = 1'($urandom);
      mem_rd     = rnd_idx();
      mem_result = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      wb_regw    = 1'($urandom);
      wb_rd      = rnd_idx();
      wb_result  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
